// File: rtl/frame_buf_scheduler_if.sv
// Handshake and bank/address bus between the frame-buffer scheduler and the
// LCD timing block / SDRAM read path.
interface frame_buf_scheduler_if #(
    parameter int ADDR_WIDTH = 24,
    parameter int CNT_WIDTH  = 8
);
    logic                  i_frame_start;
    logic                  i_wr_frame_done;
    logic                  o_read_req;
    logic                  i_read_req_ack;
    logic [1:0]            o_rd_bank;
    logic [ADDR_WIDTH-1:0] o_rd_base_addr;
    logic [1:0]            o_wr_bank;
    logic [ADDR_WIDTH-1:0] o_wr_base_addr;
    logic [CNT_WIDTH-1:0]  o_repeat_cnt;
    logic [CNT_WIDTH-1:0]  o_timeout_cnt;

    modport master (
        input  i_frame_start, i_wr_frame_done, i_read_req_ack,
        output o_read_req, o_rd_bank, o_rd_base_addr, o_wr_bank, o_wr_base_addr,
               o_repeat_cnt, o_timeout_cnt
    );

    modport slave (
        output i_frame_start, i_wr_frame_done, i_read_req_ack,
        input  o_read_req, o_rd_bank, o_rd_base_addr, o_wr_bank, o_wr_base_addr,
               o_repeat_cnt, o_timeout_cnt
    );
endinterface

// File: rtl/frame_buf_scheduler.sv
// Triple-buffer bank scheduler: rotates write/spare/read banks between the
// camera writer and the LCD reader and issues the per-frame read request.
module frame_buf_scheduler #(
    parameter int ADDR_WIDTH  = 24,
    parameter int BASE_ADDR   = 0,
    parameter int FRAME_WORDS = 384000,
    parameter int ACK_TIMEOUT = 4096,
    parameter int CNT_WIDTH   = 8
) (
    input  logic                  video_clk,
    input  logic                  rst_n,
    frame_buf_scheduler_if.master bus
);
    localparam int TW = $clog2(ACK_TIMEOUT + 1);

    localparam logic [ADDR_WIDTH-1:0] ADDR_B0 = ADDR_WIDTH'(BASE_ADDR);
    localparam logic [ADDR_WIDTH-1:0] ADDR_B1 = ADDR_WIDTH'(BASE_ADDR + FRAME_WORDS);
    localparam logic [ADDR_WIDTH-1:0] ADDR_B2 = ADDR_WIDTH'(BASE_ADDR + 2 * FRAME_WORDS);
    localparam logic [TW-1:0]         TO_LAST = TW'(ACK_TIMEOUT - 1);
    localparam logic [CNT_WIDTH-1:0]  CNT_MAX = '1;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_REQ  = 1'b1;

    logic [1:0]            r_w, r_s, r_r;
    logic                  r_fresh;
    logic [0:0]            r_state;
    logic [TW-1:0]         r_tmo;
    logic [ADDR_WIDTH-1:0] r_rd_base, r_wr_base;
    logic [CNT_WIDTH-1:0]  r_repeat_cnt, r_timeout_cnt;

    logic [1:0]            w_w, w_s, w_r;
    logic                  w_fresh;
    logic                  w_repeat_inc;
    logic [0:0]            w_state;
    logic [TW-1:0]         w_tmo;
    logic                  w_tmo_evt;

    function automatic logic [ADDR_WIDTH-1:0] bank_base(input logic [1:0] b);
        case (b)
            2'd0:    return ADDR_B0;
            2'd1:    return ADDR_B1;
            default: return ADDR_B2;
        endcase
    endfunction

    // Writer swap is applied before the reader swap so a coincident pair of
    // pulses hands the just-finished bank straight to the display.
    always_comb begin
        w_w          = r_w;
        w_s          = r_s;
        w_r          = r_r;
        w_fresh      = r_fresh;
        w_repeat_inc = 1'b0;
        if (bus.i_wr_frame_done) begin
            w_w     = r_s;
            w_s     = r_w;
            w_fresh = 1'b1;
        end
        if (bus.i_frame_start) begin
            if (w_fresh) begin
                w_r     = w_s;
                w_s     = r_r;
                w_fresh = 1'b0;
            end else begin
                w_repeat_inc = 1'b1;
            end
        end
    end

    always_comb begin
        w_state   = r_state;
        w_tmo     = r_tmo;
        w_tmo_evt = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.i_frame_start) begin
                    w_state = ST_REQ;
                    w_tmo   = '0;
                end
            end
            default: begin
                if (bus.i_frame_start) begin
                    w_tmo     = '0;
                    w_tmo_evt = 1'b1;
                end else if (bus.i_read_req_ack) begin
                    w_state = ST_IDLE;
                end else if (r_tmo == TO_LAST) begin
                    w_state   = ST_IDLE;
                    w_tmo_evt = 1'b1;
                end else begin
                    w_tmo = r_tmo + TW'(1);
                end
            end
        endcase
    end

    always_ff @(posedge video_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_w           <= 2'd0;
            r_s           <= 2'd1;
            r_r           <= 2'd2;
            r_fresh       <= 1'b0;
            r_state       <= ST_IDLE;
            r_tmo         <= '0;
            r_rd_base     <= ADDR_B2;
            r_wr_base     <= ADDR_B0;
            r_repeat_cnt  <= '0;
            r_timeout_cnt <= '0;
        end else begin
            r_w       <= w_w;
            r_s       <= w_s;
            r_r       <= w_r;
            r_fresh   <= w_fresh;
            r_state   <= w_state;
            r_tmo     <= w_tmo;
            r_rd_base <= bank_base(w_r);
            r_wr_base <= bank_base(w_w);
            if (w_repeat_inc && r_repeat_cnt != CNT_MAX) begin
                r_repeat_cnt <= r_repeat_cnt + CNT_WIDTH'(1);
            end
            if (w_tmo_evt && r_timeout_cnt != CNT_MAX) begin
                r_timeout_cnt <= r_timeout_cnt + CNT_WIDTH'(1);
            end
        end
    end

    assign bus.o_read_req     = (r_state == ST_REQ);
    assign bus.o_rd_bank      = r_r;
    assign bus.o_rd_base_addr = r_rd_base;
    assign bus.o_wr_bank      = r_w;
    assign bus.o_wr_base_addr = r_wr_base;
    assign bus.o_repeat_cnt   = r_repeat_cnt;
    assign bus.o_timeout_cnt  = r_timeout_cnt;

    a_banks_distinct: assert property (@(posedge video_clk) disable iff (!rst_n)
        (r_w != r_s) && (r_w != r_r) && (r_s != r_r));
endmodule

// File: doc/frame_buf_scheduler.md
Name: frame_buf_scheduler

Overview:
Triple-buffer bank scheduler for the SDRAM frame store between the camera writer and the LCD reader.
- Tracks three frame banks: write (W), read (R) and spare/latest (S).
- On each display frame start it picks the bank to read and issues the read-request handshake toward the SDRAM read FIFO, together with that bank's base address.
- Gives the camera writer its next bank on every completed frame.
- Sits between the LCD timing/data block (frame_start, read_req/ack) and the SDRAM controller address ports.

Parameters:
ADDR_WIDTH, 24, SDRAM word-address width
BASE_ADDR, 0, word address of bank 0
FRAME_WORDS, 384000, words per bank (800x480 at 16 bit); bank n base = BASE_ADDR + n*FRAME_WORDS
ACK_TIMEOUT, 4096, video_clk cycles to wait for read_req_ack before abandoning a request
CNT_WIDTH, 8, width of the saturating statistics counters

Ports:
video_clk  in  1  video pixel clock; all logic runs on its rising edge
rst_n  in  1  asynchronous active-low reset
frame_start  in  1  one-cycle pulse at the display vertical-sync edge
wr_frame_done  in  1  one-cycle pulse, already synchronised to video_clk: writer finished bank wr_bank
read_req  out  1  read-frame request to the SDRAM read path
read_req_ack  in  1  read request accepted (single cycle or level)
rd_bank  out  2  bank currently being displayed
rd_base_addr  out  ADDR_WIDTH  base address of rd_bank
wr_bank  out  2  bank the writer must fill next
wr_base_addr  out  ADDR_WIDTH  base address of wr_bank
repeat_cnt  out  CNT_WIDTH  frames re-displayed because no fresh frame was available (saturating)
timeout_cnt  out  CNT_WIDTH  requests abandoned on timeout or overrun (saturating)

Behaviour:
- Reset values:
  - W=0, S=1, R=2, fresh=0.
  - read_req=0, state IDLE.
  - Both counters 0.
  - Base-address outputs track the reset banks: rd_base_addr = BASE_ADDR + 2*FRAME_WORDS; wr_base_addr = BASE_ADDR.
- Bank outputs and base addresses are registered. Base-address multiply is by constant bank index only (0, 1 or 2).
- wr_frame_done: swap W and S, set fresh=1. The new wr_bank is visible the next cycle.
- frame_start:
  - fresh=1: swap R and S, clear fresh.
  - fresh=0: R unchanged, repeat_cnt++.
- Simultaneous wr_frame_done and frame_start in the same cycle: apply the writer swap first, then the reader swap. Result: R=old W, S=old R, W=old S, fresh=0, repeat_cnt unchanged.
- W, R and S are always distinct. This is an invariant and must hold in assertion.
- FSM states: IDLE, REQ.
  - IDLE to REQ on frame_start. read_req=1 from the cycle after frame_start, with rd_bank/rd_base_addr already updated in that same cycle.
  - REQ to IDLE on read_req_ack=1: read_req=0 the next cycle.
  - REQ to IDLE when ACK_TIMEOUT cycles elapse without ack: read_req drops, timeout_cnt++.
  - frame_start while in REQ (overrun): bank selection is re-evaluated as above, read_req stays 1, the timeout counter restarts at 0, timeout_cnt++.
- Ack arriving in IDLE is ignored.
- The timeout counter is cleared on entry to REQ and counts only in REQ. Width is clog2(ACK_TIMEOUT+1).
- Statistics counters hold at all-ones and never wrap.
- Asynchronous reset mid-request drops read_req immediately and restores all reset values.

Test Plan:
- Reset release with no pulses: read_req=0, R=2, W=0, rd_base_addr = 2*FRAME_WORDS = 768000, both counters 0.
- wr_frame_done, then frame_start 10 cycles later, ack 5 cycles after read_req rises: W=1, then R=0, S=2. read_req high exactly 5 cycles, repeat_cnt=0.
- Three frame_start pulses with no wr_frame_done: R stays 2, repeat_cnt=3, read_req handshake still issued each frame.
- wr_frame_done and frame_start in the same cycle from reset: R=0, S=2, W=1, fresh=0. A following frame_start gives repeat_cnt=1.
- No ack for ACK_TIMEOUT=16 (overridden): read_req high 16 cycles then 0, timeout_cnt=1. A second frame_start during REQ gives timeout_cnt+1 and read_req continuously high.
- 300 frame_start pulses without writes: repeat_cnt saturates at 255. Random pulse soak of 10k cycles with a distinct-bank assertion gives no violation.
